// File: rtl/cs_pkg.sv
// cs_pkg: shared defaults and width helpers for the cs_window block.
//   DW_DEF/N_DEF/SHIFT_DEF : default sample width, window length, output shift
//   clog2, bitw            : ceil(log2(v)) and bits needed to hold value v
//   sum_w, y_w             : running-sum width and result width
package cs_pkg;

    localparam int DW_DEF    = 8;
    localparam int N_DEF     = 9;
    localparam int SHIFT_DEF = 3;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r++;
                x = x >> 1;
            end
        end
        return r;
    endfunction

    function automatic int bitw(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r++;
                x = x >> 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int sum_w(input int dw, input int n);
        return dw + clog2(n);
    endfunction

    // Widest result is sum + N*max_sample, i.e. 2*N*(2^DW-1), then shifted.
    function automatic int y_w(input int dw, input int n, input int sh);
        return bitw((2 * n * ((1 << dw) - 1)) >> sh);
    endfunction

endpackage

// File: rtl/cs_window_if.sv
// cs_window_if: sample-in / result-out bundle for cs_window.
//   in_valid, X, mode : sample stream (master drives)
//   Y, out_valid      : registered result (slave drives)
interface cs_window_if
    import cs_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int YW = y_w(DW_DEF, N_DEF, SHIFT_DEF)
) ();
    logic          in_valid;
    logic [DW-1:0] X;
    logic          mode;
    logic [YW-1:0] Y;
    logic          out_valid;

    modport master (output in_valid, X, mode, input  Y, out_valid);
    modport slave  (input  in_valid, X, mode, output Y, out_valid);
endinterface

// File: rtl/cs_appr_search.sv
// cs_appr_search: largest window entry that is <= avg (combinational).
//   win   : N entries of DW bits
//   avg   : threshold
//   xappr : max{ win[i] : win[i] <= avg }
// Entries above the threshold are masked to zero; since the window minimum is
// never above the average, the masked maximum equals the true answer.
module cs_appr_search
    import cs_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int N  = N_DEF
) (
    input  logic [N-1:0][DW-1:0] win,
    input  logic [DW-1:0]        avg,
    output logic [DW-1:0]        xappr
);
    logic [N-1:0][DW-1:0] cand;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign cand[gi] = (win[gi] <= avg) ? win[gi] : '0;
    end

    always_comb begin
        xappr = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i] > xappr) xappr = cand[i];
        end
    end
endmodule

// File: rtl/cs_window.sv
// cs_window: sliding-window approximate-value / average filter.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : in_valid/X/mode in, Y/out_valid out (registered)
// A sample accepted at edge t updates buffer, sum, count and pointer at t;
// the result for that window is registered into Y/out_valid at t+1.
module cs_window
    import cs_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int N     = N_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    cs_window_if.slave  bus
);
    localparam int SW = sum_w(DW, N);
    localparam int YW = y_w(DW, N, SHIFT);
    localparam int TW = SW + 1;           // holds sum + N*sample
    localparam int PW = clog2(N);
    localparam int CW = clog2(N + 1);

    logic [N-1:0][DW-1:0] win;
    logic [SW-1:0]        sum;
    logic [PW-1:0]        wptr;
    logic [CW-1:0]        cnt;
    logic                 mode_r;
    logic [1:0]           vld_pipe;       // [0] result pending, [1] out_valid
    logic [YW-1:0]        y_r;

    logic [SW-1:0]        sum_nxt;
    logic                 full_nxt;
    logic [SW-1:0]        avg_w;
    logic [DW-1:0]        avg;
    logic [DW-1:0]        xappr;
    logic [TW-1:0]        term;
    logic [TW-1:0]        tot;

    assign sum_nxt  = sum + SW'(bus.X) - SW'(win[wptr]);
    assign full_nxt = (cnt >= CW'(N - 1));

    // Result path reads the registered window, i.e. the one from the last accept.
    assign avg_w = sum / SW'(N);
    assign avg   = avg_w[DW-1:0];

    cs_appr_search #(.DW(DW), .N(N)) u_search (
        .win   (win),
        .avg   (avg),
        .xappr (xappr)
    );

    assign term = TW'(N) * (mode_r ? TW'(avg) : TW'(xappr));
    assign tot  = TW'(sum) + term;

    always_ff @(posedge clk) begin
        if (reset) begin
            win      <= '0;
            sum      <= '0;
            wptr     <= '0;
            cnt      <= '0;
            mode_r   <= 1'b0;
            vld_pipe <= '0;
            y_r      <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            vld_pipe[0] <= 1'b0;
            if (vld_pipe[0]) y_r <= YW'(tot >> SHIFT);
            if (bus.in_valid) begin
                win[wptr]   <= bus.X;
                sum         <= sum_nxt;
                wptr        <= (wptr == PW'(N - 1)) ? '0 : wptr + 1'b1;
                if (cnt != CW'(N)) cnt <= cnt + 1'b1;
                mode_r      <= bus.mode;
                vld_pipe[0] <= full_nxt;
            end
        end
    end

    assign bus.Y         = y_r;
    assign bus.out_valid = vld_pipe[1];
endmodule

// File: doc/cs_window.md
CS_WINDOW -- requirements
Module: cs_window

Interface
REQ-001 SHALL have parameter DW, default 8, sample width in bits (4..16).
REQ-002 SHALL have parameter N, default 9, window length in samples (3..16, need not be a power of 2).
REQ-003 SHALL have parameter SHIFT, default 3, output right-shift applied to the final sum.
REQ-004 SHALL have derived localparams SW = DW+clog2(N) (sum width) and YW = bit width of (2*N*(2^DW-1))>>SHIFT (10 at defaults).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1, X holds a sample to accept at this edge.
REQ-008 SHALL have port X, input, DW, unsigned sample.
REQ-009 SHALL have port mode, input, 1, 0 = approximate-value mode, 1 = plain-average mode; sampled together with X.
REQ-010 SHALL have port Y, output, YW, registered unsigned result.
REQ-011 SHALL have port out_valid, output, 1, registered; Y carries a new result this cycle.

Function
REQ-012 SHALL keep the last N accepted samples in a circular buffer; a write pointer advances 0..N-1 and wraps from N-1 to 0.
REQ-013 SHALL keep a running sum: sum_next = sum + X - oldest, where oldest is the entry being overwritten; SW bits, no overflow possible.
REQ-014 SHALL keep a fill counter that increments per accepted sample and saturates at N.
REQ-015 SHALL use avg = floor(sum/N), computed from the updated sum and buffer.
REQ-016 SHALL define Xappr as the largest window sample <= avg; the window minimum is always <= avg, so Xappr always exists.
REQ-017 SHALL output Y = (sum + N*Xappr) >> SHIFT when mode = 0, and Y = (sum + N*avg) >> SHIFT when mode = 1, truncated (floor).
REQ-018 SHALL apply a latency of one cycle: with a sample accepted at edge t (in_valid=1), the buffer, sum and count update at t, and Y/out_valid update at t+1 from that window.
REQ-019 SHALL assert out_valid at t+1 only if the fill count equals N after edge t; it is a one-cycle pulse per accepted sample.
REQ-020 SHALL, when in_valid=0, leave the buffer, sum, count and pointer unchanged; at the next edge out_valid=0 and Y holds its last value.
REQ-021 SHALL register mode with the sample; a mode change affects only results of samples accepted with the new mode.
REQ-022 SHALL resolve ties in the search by value only, so duplicate samples equal to Xappr give the same Y.

Reset
REQ-023 SHALL, while reset=1 at an edge, clear the buffer, sum, count, pointer, Y (0) and out_valid (0); reset wins over a simultaneous in_valid.
REQ-024 SHALL, after reset mid-stream, discard the partial window; out_valid stays 0 until N new samples have been accepted.

Structure
REQ-025 SHALL place the DW/N/SHIFT defaults, the SW/YW width functions and clog2 in shared package cs_pkg.
REQ-026 SHALL implement the combinational max-below-threshold search over N entries as sub-module cs_appr_search (inputs: buffer, avg; output: Xappr).
REQ-027 SHALL contain no latches and no multicycle paths; the division by constant N is combinational and resolved by synthesis.

Verification (defaults DW=8, N=9, SHIFT=3)
REQ-028 SHALL cover: reset, then 9 samples of 0x10, mode=0, in_valid continuous -> out_valid first high the cycle after the 9th accept, Y=0x024; no out_valid before that.
REQ-029 SHALL cover: samples 0 x8 then 90 (0x5A) -> avg=10, Xappr=0, Y=0x00B (mode=0); the same sequence with mode=1 -> Y=0x016.
REQ-030 SHALL cover: 9 samples of 0xFF -> Y=0x23D (full-scale, no overflow).
REQ-031 SHALL cover: samples 1..9 -> Y=0x00B; then sample 10 (wrap, oldest=1 dropped) -> sum=54, avg=6, Y=0x00D.
REQ-032 SHALL cover: in_valid low for 3 cycles mid-stream -> out_valid=0 and Y unchanged for those cycles; the next accept continues the window correctly.
REQ-033 SHALL cover: reset after 5 samples, then 8 samples -> no out_valid; the 9th sample -> out_valid=1 with the Y of the new window only.
